// File: rtl/calc1_if.sv
// Request/response signal bundle for the four calc1 ports; element k serves port k+1.
// The device keeps its flat port list, so the bench wires these elements to it by name.
interface calc1_if;
    logic [0:3]  cmd      [4];
    logic [0:31] data     [4];
    logic [0:31] out_data [4];
    logic [0:1]  out_resp [4];

    modport master (output cmd, data, input out_data, out_resp);
    modport slave  (input cmd, data, output out_data, out_resp);
endinterface

// File: rtl/calc1.sv
// Four-port calculator: each port runs its own IDLE/OP2/WAIT/RESP sequence and
// shares one add/sub unit and one shift unit under fixed priority (port 1 highest).
module calc1 (
    output logic [0:31] out_data1,
    output logic [0:31] out_data2,
    output logic [0:31] out_data3,
    output logic [0:31] out_data4,
    output logic [0:1]  out_resp1,
    output logic [0:1]  out_resp2,
    output logic [0:1]  out_resp3,
    output logic [0:1]  out_resp4,
    input  logic        c_clk,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    input  logic [1:7]  reset
);

    typedef enum logic [1:0] {IDLE, OP2, WAIT, RESP} state_t;

    localparam logic [0:3] CMD_NOP = 4'd0;
    localparam logic [0:3] CMD_ADD = 4'd1;
    localparam logic [0:3] CMD_SUB = 4'd2;
    localparam logic [0:3] CMD_SHL = 4'd5;
    localparam logic [0:3] CMD_SHR = 4'd6;

    logic        rst;
    logic [0:3]  cmd_in   [4];
    logic [0:31] data_in  [4];
    logic [0:3]  cmd_cur  [4];
    logic [0:31] op1_cur  [4];
    logic [0:31] op2_cur  [4];
    logic [0:31] data_out [4];
    logic [0:1]  resp_out [4];
    logic [3:0]  want_alu, want_sh, grant_alu, grant_sh;

    assign rst = |reset;

    assign cmd_in[0]  = req1_cmd_in;
    assign cmd_in[1]  = req2_cmd_in;
    assign cmd_in[2]  = req3_cmd_in;
    assign cmd_in[3]  = req4_cmd_in;
    assign data_in[0] = req1_data_in;
    assign data_in[1] = req2_data_in;
    assign data_in[2] = req3_data_in;
    assign data_in[3] = req4_data_in;

    assign out_data1 = data_out[0];
    assign out_data2 = data_out[1];
    assign out_data3 = data_out[2];
    assign out_data4 = data_out[3];
    assign out_resp1 = resp_out[0];
    assign out_resp2 = resp_out[1];
    assign out_resp3 = resp_out[2];
    assign out_resp4 = resp_out[3];

    logic [0:3]  alu_cmd;
    logic [0:31] alu_a, alu_b, sh_a;
    logic [0:4]  sh_amt;
    logic        sh_left;

    // Grants are one-hot per unit, so the operand muxes reduce to a simple scan.
    always_comb begin
        alu_cmd = '0;
        alu_a   = '0;
        alu_b   = '0;
        sh_a    = '0;
        sh_amt  = '0;
        sh_left = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (grant_alu[i]) begin
                alu_cmd = cmd_cur[i];
                alu_a   = op1_cur[i];
                alu_b   = op2_cur[i];
            end
            if (grant_sh[i]) begin
                sh_a    = op1_cur[i];
                sh_amt  = op2_cur[i][27:31];
                sh_left = (cmd_cur[i] == CMD_SHL);
            end
        end
    end

    logic [32:0] alu_sum;
    logic [0:31] alu_data, sh_data;
    logic [0:1]  alu_resp;

    assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign sh_data = sh_left ? (sh_a << sh_amt) : (sh_a >> sh_amt);

    // Invalid opcodes fall through to the error response but still occupy the unit.
    always_comb begin
        alu_data = '0;
        alu_resp = 2'd2;
        case (alu_cmd)
            CMD_ADD: if (!alu_sum[32]) begin
                alu_data = alu_sum[31:0];
                alu_resp = 2'd1;
            end
            CMD_SUB: if (alu_b <= alu_a) begin
                alu_data = alu_a - alu_b;
                alu_resp = 2'd1;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_port
        state_t      state_reg, state_next;
        logic [0:3]  cmd_reg;
        logic [0:31] op1_reg, op2_reg, res_data_reg, out_data_reg;
        logic [0:1]  res_resp_reg, out_resp_reg;
        logic        is_shift, granted;

        assign is_shift      = (cmd_reg == CMD_SHL) || (cmd_reg == CMD_SHR);
        assign want_alu[gi]  = (state_reg == WAIT) && !is_shift;
        assign want_sh[gi]   = (state_reg == WAIT) && is_shift;
        assign grant_alu[gi] = want_alu[gi] && !(|(want_alu & ((4'd1 << gi) - 4'd1)));
        assign grant_sh[gi]  = want_sh[gi] && !(|(want_sh & ((4'd1 << gi) - 4'd1)));
        assign granted       = grant_alu[gi] | grant_sh[gi];

        assign cmd_cur[gi]  = cmd_reg;
        assign op1_cur[gi]  = op1_reg;
        assign op2_cur[gi]  = op2_reg;
        assign data_out[gi] = out_data_reg;
        assign resp_out[gi] = out_resp_reg;

        always_comb begin
            state_next = state_reg;
            case (state_reg)
                IDLE:    if (cmd_in[gi] != CMD_NOP) state_next = OP2;
                OP2:     state_next = WAIT;
                WAIT:    if (granted) state_next = RESP;
                RESP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        always_ff @(posedge c_clk or posedge rst) begin
            if (rst) begin
                state_reg    <= IDLE;
                cmd_reg      <= '0;
                op1_reg      <= '0;
                op2_reg      <= '0;
                res_data_reg <= '0;
                res_resp_reg <= '0;
                out_data_reg <= '0;
                out_resp_reg <= '0;
            end else begin
                state_reg <= state_next;
                if (state_reg == IDLE && cmd_in[gi] != CMD_NOP) begin
                    cmd_reg <= cmd_in[gi];
                    op1_reg <= data_in[gi];
                end
                if (state_reg == OP2)
                    op2_reg <= data_in[gi];
                if (granted) begin
                    res_data_reg <= is_shift ? sh_data : alu_data;
                    res_resp_reg <= is_shift ? 2'd1 : alu_resp;
                end
                out_data_reg <= (state_reg == RESP) ? res_data_reg : '0;
                out_resp_reg <= (state_reg == RESP) ? res_resp_reg : 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_calc1.sv
// Bench for calc1: a vector table run one command at a time, then hand-built
// sequences for contention, ignored commands and reset; a per-port queue scores responses.
module tb_calc1;
    logic       clk = 1'b0;
    logic [1:7] reset;
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;

    calc1_if bus();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc1 dut (
        .out_data1   (bus.out_data[0]),
        .out_data2   (bus.out_data[1]),
        .out_data3   (bus.out_data[2]),
        .out_data4   (bus.out_data[3]),
        .out_resp1   (bus.out_resp[0]),
        .out_resp2   (bus.out_resp[1]),
        .out_resp3   (bus.out_resp[2]),
        .out_resp4   (bus.out_resp[3]),
        .c_clk       (clk),
        .req1_cmd_in (bus.cmd[0]),
        .req1_data_in(bus.data[0]),
        .req2_cmd_in (bus.cmd[1]),
        .req2_data_in(bus.data[1]),
        .req3_cmd_in (bus.cmd[2]),
        .req3_data_in(bus.data[2]),
        .req4_cmd_in (bus.cmd[3]),
        .req4_data_in(bus.data[3]),
        .reset       (reset)
    );

    typedef struct {
        int          port;
        logic [0:3]  cmd;
        logic [0:31] op1;
        logic [0:31] op2;
        logic [0:1]  resp;
        logic [0:31] data;
    } vec_t;

    typedef struct {
        logic [0:1]  resp;
        logic [0:31] data;
        int          due;
    } exp_t;

    vec_t vecs [17];
    exp_t exp_q [4][$];

    // Group stimulus for same-edge commands on all four ports.
    logic [0:3]  g_cmd  [4];
    logic [0:31] g_op1  [4];
    logic [0:31] g_op2  [4];
    logic [0:1]  g_resp [4];
    logic [0:31] g_data [4];
    int          g_lat  [4];

    always @(negedge clk) begin : mon
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            if (bus.out_resp[p] != 2'd0) begin
                tests++;
                if (exp_q[p].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp port%0d: got resp %0d data %h at cycle %0d, required no response",
                             p + 1, bus.out_resp[p], bus.out_data[p], cyc);
                end else begin
                    e = exp_q[p].pop_front();
                    if (bus.out_resp[p] !== e.resp || bus.out_data[p] !== e.data || cyc != e.due) begin
                        fails++;
                        $display("FAIL resp_port%0d: got resp %0d data %h cycle %0d, required resp %0d data %h cycle %0d",
                                 p + 1, bus.out_resp[p], bus.out_data[p], cyc, e.resp, e.data, e.due);
                    end else begin
                        $display("[TB] port%0d resp %0d data %h cycle %0d", p + 1, bus.out_resp[p], bus.out_data[p], cyc);
                    end
                end
            end else begin
                tests++;
                if (bus.out_data[p] !== 32'h0) begin
                    fails++;
                    $display("FAIL idle_data_port%0d: got data %h with resp 0, required 00000000", p + 1, bus.out_data[p]);
                end
                if (exp_q[p].size() > 0 && cyc > exp_q[p][0].due) begin
                    fails++;
                    $display("FAIL missing_resp_port%0d: got no response by cycle %0d, required resp %0d data %h at cycle %0d",
                             p + 1, cyc, exp_q[p][0].resp, exp_q[p][0].data, exp_q[p][0].due);
                    void'(exp_q[p].pop_front());
                end
            end
        end
    end

    function automatic int outstanding();
        return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    endfunction

    // Called in the low phase; returns in the low phase two cycles later.
    task automatic issue(input int p, input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                         input logic [0:1] er, input logic [0:31] ed);
        exp_t e;
        e.resp = er;
        e.data = ed;
        e.due  = cyc + 4;
        exp_q[p].push_back(e);
        bus.cmd[p]  = c;
        bus.data[p] = a;
        @(negedge clk);
        bus.cmd[p]  = 4'd0;
        bus.data[p] = b;
        @(negedge clk);
        bus.data[p] = '0;
    endtask

    task automatic issue_group();
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            e.resp = g_resp[p];
            e.data = g_data[p];
            e.due  = cyc + 4 + g_lat[p];
            exp_q[p].push_back(e);
            bus.cmd[p]  = g_cmd[p];
            bus.data[p] = g_op1[p];
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            bus.cmd[p]  = 4'd0;
            bus.data[p] = g_op2[p];
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) bus.data[p] = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (outstanding() > 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (outstanding() > 0) begin
            fails++;
            $display("FAIL drain: got %0d responses outstanding, required 0", outstanding());
        end
    endtask

    initial begin
        vecs[0]  = '{0, 4'd1,  32'h00000005, 32'h00000007, 2'd1, 32'h0000000C};
        vecs[1]  = '{1, 4'd1,  32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h00000000};
        vecs[2]  = '{1, 4'd1,  32'h7FFFFFFF, 32'h00000001, 2'd1, 32'h80000000};
        vecs[3]  = '{2, 4'd2,  32'h00000003, 32'h00000005, 2'd2, 32'h00000000};
        vecs[4]  = '{2, 4'd2,  32'h00000005, 32'h00000005, 2'd1, 32'h00000000};
        vecs[5]  = '{3, 4'd5,  32'h00000001, 32'h0000001F, 2'd1, 32'h80000000};
        vecs[6]  = '{3, 4'd6,  32'h80000000, 32'h00000021, 2'd1, 32'h40000000};
        vecs[7]  = '{0, 4'd3,  32'h00000004, 32'h00000002, 2'd2, 32'h00000000};
        vecs[8]  = '{0, 4'd2,  32'h0000000A, 32'h00000003, 2'd1, 32'h00000007};
        vecs[9]  = '{1, 4'd15, 32'h00000001, 32'h00000001, 2'd2, 32'h00000000};
        vecs[10] = '{2, 4'd5,  32'hF0000001, 32'h00000004, 2'd1, 32'h00000010};
        vecs[11] = '{3, 4'd6,  32'hFFFFFFFF, 32'h00000000, 2'd1, 32'hFFFFFFFF};
        vecs[12] = '{0, 4'd4,  32'h00000009, 32'h00000009, 2'd2, 32'h00000000};
        vecs[13] = '{1, 4'd1,  32'h00000000, 32'h00000000, 2'd1, 32'h00000000};
        vecs[14] = '{2, 4'd1,  32'h80000000, 32'h80000000, 2'd2, 32'h00000000};
        vecs[15] = '{3, 4'd6,  32'h12345678, 32'h00000024, 2'd1, 32'h01234567};
        vecs[16] = '{0, 4'd7,  32'h00000001, 32'h00000002, 2'd2, 32'h00000000};

        reset = '1;
        for (int p = 0; p < 4; p++) begin
            bus.cmd[p]  = 4'd0;
            bus.data[p] = '0;
        end
        repeat (3) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            tests++;
            if (bus.out_resp[p] !== 2'd0 || bus.out_data[p] !== 32'h0) begin
                fails++;
                $display("FAIL reset_state_port%0d: got resp %0d data %h, required 0 and 00000000",
                         p + 1, bus.out_resp[p], bus.out_data[p]);
            end
        end
        reset = '0;

        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].port, vecs[i].cmd, vecs[i].op1, vecs[i].op2, vecs[i].resp, vecs[i].data);
            wait_drain();
        end

        // Four adds on one edge serialise on the add/sub unit in port order.
        for (int p = 0; p < 4; p++) begin
            g_cmd[p]  = 4'd1;
            g_op1[p]  = 32'(100 * (p + 1));
            g_op2[p]  = 32'(p + 1);
            g_resp[p] = 2'd1;
            g_data[p] = 32'(101 * (p + 1));
            g_lat[p]  = p;
        end
        issue_group();
        wait_drain();

        // Invalid+add share the add/sub unit; two shifts share the shift unit; units run in parallel.
        g_cmd[0] = 4'd3; g_op1[0] = 32'h5;   g_op2[0] = 32'h1; g_resp[0] = 2'd2; g_data[0] = 32'h0;  g_lat[0] = 0;
        g_cmd[1] = 4'd1; g_op1[1] = 32'h1;   g_op2[1] = 32'h1; g_resp[1] = 2'd1; g_data[1] = 32'h2;  g_lat[1] = 1;
        g_cmd[2] = 4'd5; g_op1[2] = 32'h3;   g_op2[2] = 32'h2; g_resp[2] = 2'd1; g_data[2] = 32'hC;  g_lat[2] = 0;
        g_cmd[3] = 4'd6; g_op1[3] = 32'h100; g_op2[3] = 32'h8; g_resp[3] = 2'd1; g_data[3] = 32'h1;  g_lat[3] = 1;
        issue_group();
        wait_drain();

        // Commands held high outside IDLE must be ignored: exactly one response.
        begin
            exp_t e;
            e.resp = 2'd1;
            e.data = 32'd13;
            e.due  = cyc + 4;
            exp_q[1].push_back(e);
        end
        bus.cmd[1] = 4'd1; bus.data[1] = 32'd10;
        @(negedge clk);
        bus.cmd[1] = 4'd2; bus.data[1] = 32'd3;
        @(negedge clk);
        bus.cmd[1] = 4'd1; bus.data[1] = 32'd100;
        @(negedge clk);
        @(negedge clk);
        bus.cmd[1] = 4'd0; bus.data[1] = '0;
        wait_drain();
        repeat (6) @(negedge clk);

        // Reset clears a visible response without waiting for a clock edge.
        issue(1, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);
        for (int n = 0; n < 10 && exp_q[1].size() > 0; n++) begin
            @(negedge clk);
            #1;
        end
        #1;
        reset = '1;
        #1;
        for (int p = 0; p < 4; p++) begin
            tests++;
            if (bus.out_resp[p] !== 2'd0 || bus.out_data[p] !== 32'h0) begin
                fails++;
                $display("FAIL async_reset_port%0d: got resp %0d data %h, required 0 and 00000000",
                         p + 1, bus.out_resp[p], bus.out_data[p]);
            end
        end
        @(negedge clk);
        reset = '0;
        repeat (2) @(negedge clk);

        // A reset (one bit only) while in WAIT discards the command; the next edge accepts a fresh one.
        bus.cmd[0] = 4'd1; bus.data[0] = 32'd1;
        @(negedge clk);
        bus.cmd[0] = 4'd0; bus.data[0] = 32'd2;
        @(negedge clk);
        bus.data[0] = '0;
        reset = 7'b0000001;
        @(negedge clk);
        reset = '0;
        issue(0, 4'd1, 32'h10, 32'h20, 2'd1, 32'h30);
        wait_drain();
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/calc1.md
CALC1 -- requirements
Module: calc1

Interface
REQ-001 The block SHALL use one clock, c_clk, and an asynchronous, active-high reset named reset.
REQ-002 The reset input SHALL be a 7-bit bus, reset[1:7]; any bit high resets the block, and drivers assert all bits together.
REQ-003 Port list, in positional order:
- out_data1..out_data4 -- output, 32 bits each, result per port.
- out_resp1..out_resp4 -- output, 2 bits each, response code per port.
- c_clk -- input, 1 bit, clock, rising edge active.
- req1_cmd_in, req1_data_in through req4_cmd_in, req4_data_in -- input, 4 and 32 bits each, interleaved per port.
- reset -- input, 7 bits, asynchronous active-high reset.
REQ-004 All buses SHALL be MSB-first: [0:31] for data, [0:3] for commands, [0:1] for responses.

Function
REQ-005 Commands SHALL be encoded as follows:
- 0: no-op
- 1: add
- 2: subtract
- 5: shift left
- 6: shift right
- all other values: invalid
REQ-006 Response codes SHALL be encoded as follows:
- 0: none
- 1: success
- 2: overflow, underflow or invalid command
- 3: never driven
REQ-007 Each port SHALL be an independent state machine with states IDLE -> OP2 -> WAIT -> RESP -> IDLE.
REQ-008 In IDLE, a nonzero cmd on a rising edge SHALL capture cmd and data (operand 1); the next edge SHALL capture data as operand 2 (state OP2), regardless of the cmd value on that cycle.
REQ-009 A port SHALL accept a new command only in IDLE; a nonzero cmd in any other state is ignored; a requester waits for a nonzero response before issuing its next command.
REQ-010 There SHALL be one add/sub unit and one shift unit, each executing at most one operation per cycle, both usable in the same cycle.
REQ-011 When several WAIT ports contend for the same unit, fixed priority SHALL apply: port 1 > 2 > 3 > 4; losers stay in WAIT.
REQ-012 Earliest timing for a command issued at edge T:
- operand 2 captured at T+1
- operation executed at T+2
- out_resp/out_data valid for exactly one cycle after edge T+3
REQ-013 Add SHALL compute op1 + op2 as unsigned 32-bit; a carry out of bit 31 gives resp 2 with data 0.
REQ-014 Subtract SHALL compute op1 - op2 as unsigned 32-bit; op2 > op1 gives resp 2 with data 0; op1 == op2 gives resp 1 with data 0.
REQ-015 Shifts SHALL be logical, shifting op1 by op2[27:31] (0-31, the low 5 bits); zero fill; always resp 1.
REQ-016 Invalid commands SHALL still consume an operand-2 cycle and a unit slot (add/sub unit); they give resp 2 with data 0.
REQ-017 When out_resp is 0, out_data SHALL be 0.
REQ-018 Each port produces at most one response per accepted command; response order across ports is unconstrained beyond REQ-011.
REQ-019 Every output SHALL be registered.

Reset
REQ-020 While reset is high:
- all out_data SHALL be 0 and all out_resp SHALL be 0 immediately (asynchronous);
- all ports SHALL return to IDLE;
- captured operands SHALL be cleared.
REQ-021 Reset asserted mid-operation SHALL discard every in-flight command; no response is ever issued for it.
REQ-022 After reset deasserts, the first rising edge SHALL be able to accept a command.

Verification
REQ-023 Port 1 add, op1=0x00000005, op2=0x00000007 -> out_resp1=1, out_data1=0x0000000C, 3 cycles after the command edge.
REQ-024 Port 2 add, 0xFFFFFFFF + 0x00000001 -> out_resp2=2, out_data2=0; then 0x7FFFFFFF + 0x00000001 -> resp 1, data 0x80000000.
REQ-025 Port 3 subtract, 3-5 -> resp 2, data 0; subtract 5-5 -> resp 1, data 0.
REQ-026 Port 4 shift left, 0x00000001 by 31 -> resp 1, data 0x80000000; shift right, 0x80000000 by 0x00000021 (31+2, low 5 bits = 1) -> resp 1, data 0x40000000.
REQ-027 Ports 1-4 issue add on the same edge -> responses in order port1, port2, port3, port4 on consecutive cycles; cmd 3 on port 1 -> resp 2, data 0.
REQ-028 Reset pulse between command and response -> no response is issued; a fresh command afterwards completes normally.
